// File: rtl/mips32_reg_dump.sv
// Register-file readout engine: after a HALTED rising edge or a start pulse it
// streams a header word and then every register, in ascending order, on a valid/ready port.
module mips32_reg_dump #(
  parameter int          NREG    = 32,
  parameter int          AW      = 5,
  parameter int          DW      = 32,
  parameter logic [15:0] HDR_TAG = 16'hD0D0
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          start,
  output logic [AW-1:0] reg_addr,
  input  logic [DW-1:0] reg_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  // idx must reach NREG itself (one past the last register) without wrapping.
  localparam int            IW       = (AW > 8) ? AW + 1 : 9;
  localparam logic [IW-1:0] LAST_IDX = IW'(NREG - 1);
  localparam logic [DW-1:0] HDR_WORD = (DW'(HDR_TAG) << (DW - 16)) | DW'(8'(NREG));

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            halted_q, halted_d;
  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_last_q, m_last_d;
  logic            done_q, done_d;
  logic            trigger;
  logic            handshake;

  assign trigger   = start | (halted & ~halted_q);
  assign handshake = m_valid_q & m_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    halted_d  = halted;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    done_d    = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (trigger) begin
          state_d   = S_HDR;
          m_valid_d = 1'b1;
          m_data_d  = HDR_WORD;
          m_last_d  = 1'b0;
          idx_d     = '0;
          done_d    = 1'b0;
        end
      end
      S_HDR: begin
        if (handshake) begin
          state_d  = S_DATA;
          m_data_d = reg_data;
          m_last_d = (idx_q == LAST_IDX);
          idx_d    = idx_q + 1'b1;
        end
      end
      S_DATA: begin
        if (handshake) begin
          if (m_last_q) begin
            state_d   = S_DONE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            done_d    = 1'b1;
          end else begin
            // reg_addr follows idx, so reg_data here is the next register to present.
            m_data_d = reg_data;
            m_last_d = (idx_q == LAST_IDX);
            idx_d    = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      halted_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      halted_q  <= halted_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
    end
  end

  assign reg_addr = idx_q[AW-1:0];
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign busy     = (state_q == S_HDR) || (state_q == S_DATA);
  assign done     = done_q;

endmodule

// File: doc/mips32_reg_dump.md
# mips32_reg_dump

Post-halt register-file readout engine for the pipelined MIPS32 core. When the core asserts HALTED, or on an explicit start pulse, it walks the register file through a read port. It emits a framed stream on a valid/ready interface: one header word, then every register in ascending index order. Bench monitors and a future debug UART consume this stream instead of peeking at the register array hierarchically.

## Interface
- NREG, 32: number of registers dumped; legal range 2..255.
- AW, 5: register address width; 2**AW >= NREG.
- DW, 32: register/data word width; DW >= 24.
- HDR_TAG, 16'hD0D0: tag placed in header bits [DW-1:DW-16].
- clk1  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- halted  in  1  core HALTED flag; a 0->1 transition triggers a dump.
- start  in  1  single-cycle dump request, independent of halted.
- reg_addr  out  AW  register-file read address.
- reg_data  in  DW  register-file read data; combinational from reg_addr.
- m_valid  out  1  stream word valid.
- m_ready  in  1  consumer accepts word when m_valid && m_ready.
- m_data  out  DW  stream word.
- m_last  out  1  marks final word of frame.
- busy  out  1  high from trigger acceptance until last word accepted.
- done  out  1  sticky, high after a complete frame.

## Operation
- States: IDLE, HDR, DATA, DONE.
- halted_q is a register of halted. Trigger = start | (halted & ~halted_q).
- IDLE: on trigger -> HDR, with m_valid=1, m_data={HDR_TAG, zeros, NREG[7:0]}, m_last=0, idx=0.
- HDR: on handshake, load m_data<=reg_data at reg_addr=idx (0), then idx<=1 -> DATA.
- DATA: on handshake while idx < NREG, load m_data<=reg_data at reg_addr=idx, set m_last<=(idx==NREG-1), and idx<=idx+1.
- DATA: on handshake with m_last=1, drop m_valid and m_last -> DONE, with done<=1.
- reg_addr = idx[AW-1:0] combinationally, so data is sampled on the same edge as the preceding handshake.
- Frame length is exactly NREG+1 words; no gaps are inserted by the block.
- DONE: trigger -> HDR (new frame), with done<=0. halted falling does not clear done.
- Trigger while in HDR/DATA is ignored; no queuing.
- halted falling mid-frame: the frame completes unchanged.
- busy = (state==HDR)|(state==DATA).

## Timing
- Reset values: m_valid=0, m_data=0, m_last=0, busy=0, done=0, reg_addr=0, idx=0, halted_q=0, state IDLE.
- Reset mid-frame: on the next edge, all outputs return to reset values. The partial frame is abandoned without asserting m_last.
- Trigger sampled at edge N: m_valid=1 with the header during cycle N+1.
- No backpressure: one word per cycle. The header appears at N+1, Reg[k] at N+2+k, and m_last with Reg[NREG-1] at N+1+NREG.
- The first edge after the last handshake gives m_valid=0, busy=0, done=1.
- While m_valid && !m_ready, m_data, m_last and reg_addr are held constant. m_valid never drops without a handshake, except on reset.
- reg_data is sampled only on handshake edges, so register-file changes between handshakes are not reflected in the already-presented word.
- halted held high continuously causes exactly one dump; a re-trigger requires a 1->0->1 transition or a start pulse.

## Test plan
- Preload Reg[k]=k, run the program ADDI R1=10, R2=20, R3=25, R4=R1+R2, R5=R4+R3, HLT, with m_ready=1.
  - Required: header 32'hD0D00020.
  - Required: words 0,10,20,25,30,55,6,7,...,31.
  - Required: m_last on the 33rd word only, then done=1.
- Same run with m_ready toggling pseudo-randomly.
  - Required: an identical 33-word sequence.
  - Required: m_data stable throughout every stalled cycle.
- Keep halted=1 for 100 cycles after a frame.
  - Required: no second frame.
- Pulse start in DONE.
  - Required: a new frame with done low until it completes.
- Pulse start at word 10 of a frame.
  - Required: the pulse is ignored and exactly one 33-word frame is produced.
- Assert rst_n=0 for one cycle at word 5.
  - Required: m_valid=0 and busy=0 on the next edge.
  - Required: no m_last seen.
  - Required: a subsequent start gives a full, correct frame.
